error_controller: RTL and testbench
===================================

# error_controller

Backward-pass counterpart of the forward layer controller. For each layer index issued by the training sequencer, it computes per-neuron deltas, delta_i = error_i · σ'(a_i):
- at the output layer, the error is target minus activation;
- at hidden layers, the error is the propagated error returned by the layer module.

The block sits between the activation store, the layer module's error-propagation output, and the weight-update path. It uses one shared multiplier and processes neurons serially.

## Interface
Parameters:
- NEURON_NUM, 5, neurons per layer
- ACTIVATION_WIDTH, 9, unsigned activation width (AW); value a represents a/2^AW
- DELTA_WIDTH, 10, signed error/delta width (DW); must be ≥ AW+1
- LAYER_ADDR_WIDTH, 2, layer index width
- LAYER_MAX, 2, index of the output layer

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- layer_number  in  LAYER_ADDR_WIDTH  layer whose deltas are requested
- layer_number_valid / layer_number_ready  in / out  1  handshake
- start_targets  in  NEURON_NUM*AW  training targets, unsigned, neuron i at bits [i*AW +: AW]
- start_targets_valid / start_targets_ready  in / out  1  handshake
- activations  in  NEURON_NUM*AW  stored activations of the requested layer
- activations_valid / activations_ready  in / out  1  handshake
- propagated_error  in  NEURON_NUM*DW  signed errors from the layer module
- propagated_error_valid / propagated_error_ready  in / out  1  handshake
- deltas  out  NEURON_NUM*DW  signed deltas, neuron i at bits [i*DW +: DW]
- deltas_valid / deltas_ready  out / in  1  handshake

## Operation
- A transfer occurs on a rising edge where valid && ready are both 1. Data is sampled on that edge.
- States: IDLE, LOAD, COMPUTE, OUTPUT. All readies and deltas_valid are decoded from the state and capture flags only; none depends combinationally on any valid.
- IDLE:
  - layer_number_ready = 1.
  - On transfer, latch the layer index and set mode OUT (index == LAYER_MAX) or HID (0 < index < LAYER_MAX), then go to LOAD.
  - Index 0 or index > LAYER_MAX: consumed and dropped. Stay in IDLE; no other stream is touched and no delta is produced.
- LOAD:
  - activations_ready = 1 until activations are captured.
  - Mode OUT: start_targets_ready = 1 until captured; propagated_error_ready stays 0.
  - Mode HID: propagated_error_ready = 1 until captured; start_targets_ready stays 0.
  - Each stream is captured independently, in either order or on the same edge. Its ready drops the cycle after its capture.
  - Go to COMPUTE when both required operands are held.
- COMPUTE:
  - A neuron counter i runs 0..NEURON_NUM-1, one neuron per cycle.
  - Error e: OUT mode uses sign-extended (t_i − a_i) at AW+1 bits, extended to DW. HID mode uses the DW-bit propagated_error_i.
  - Derivative d = (a_i · (2^AW − a_i)) >> AW, unsigned AW bits.
  - Product p = e · d, signed, DW+AW+1 bits.
  - delta_i = saturate_DW(p >>> AW); arithmetic shift, rounding toward −∞.
  - After i = NEURON_NUM-1, go to OUTPUT.
- OUTPUT:
  - deltas_valid = 1, with deltas holding all NEURON_NUM results.
  - deltas stays stable while deltas_ready = 0.
  - On transfer, go to IDLE and clear the capture flags.

## Timing
- While rst = 0, and at its release:
  - state = IDLE, capture flags and counter = 0.
  - deltas = 0, deltas_valid = 0.
  - start_targets_ready = activations_ready = propagated_error_ready = 0.
  - layer_number_ready = 1, since it is decoded from IDLE.
- Reset asserted mid-LOAD, COMPUTE or OUTPUT: the operation is aborted immediately and any partial deltas are discarded. The first operation after reset must be bit-exact.
- Latency: if the last operand transfers on edge k, delta_0 is computed on edge k+1. deltas_valid rises after edge k+NEURON_NUM, so it is first sampled high on edge k+NEURON_NUM+1.
- Best case with all inputs valid, NEURON_NUM = 5 and deltas_ready = 1:
  - 1 cycle IDLE, 1 cycle LOAD, 5 cycles COMPUTE, 1 cycle OUTPUT.
  - 8 cycles per layer.
- No new layer_number is accepted until the OUTPUT transfer completes; layer_number_ready = 0 outside IDLE.
- An operand stream that is unused in the current mode must see ready = 0 for the entire operation, whatever its valid does.

## Test plan
All scenarios use default parameters.
- OUT mode, target = 511 and activation = 256 on all neurons, layer 2 → every delta = 63. Then target = 0, act = 256 → −64. Then act = 0 → 0.
- HID mode, layer 1, propagated_error = −100, act = 128 → delta = −19 (d = 96). Check that start_targets_ready is never 1 even with start_targets_valid held high.
- Operand ordering: present activations 3 cycles after start_targets, then the reverse order, then both on the same edge → identical deltas; each ready drops the cycle after its capture; deltas_valid is first sampled high 6 edges after the last capture.
- Backpressure: hold deltas_ready = 0 for 5 cycles in OUTPUT → deltas stable and deltas_valid = 1 throughout; layer_number_ready = 0 until the transfer, then 1 the next cycle.
- Layer 0 and layer 3 requests → consumed in one cycle; no operand ready rises and no deltas_valid is produced.
- Reset pulse at COMPUTE i = 2 → all outputs return to their reset values asynchronously; a following layer-2 request with the first scenario's values yields 63 on every neuron.

Source files
------------

// File: rtl/error_controller.sv
// error_controller: backward-pass delta engine.
// For each requested layer it computes delta_i = error_i * a_i*(1-a_i), one
// neuron per cycle, on a single serial multiply datapath. Output layers use
// (target - activation) as the error. Hidden layers use the propagated error.
module error_controller #(
    parameter int NEURON_NUM       = 5,
    parameter int ACTIVATION_WIDTH = 9,
    parameter int DELTA_WIDTH      = 10,
    parameter int LAYER_ADDR_WIDTH = 2,
    parameter int LAYER_MAX        = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [LAYER_ADDR_WIDTH-1:0]           layer_number,
    input  logic                                  layer_number_valid,
    output logic                                  layer_number_ready,
    input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0] start_targets,
    input  logic                                  start_targets_valid,
    output logic                                  start_targets_ready,
    input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0] activations,
    input  logic                                  activations_valid,
    output logic                                  activations_ready,
    input  logic [NEURON_NUM*DELTA_WIDTH-1:0]      propagated_error,
    input  logic                                  propagated_error_valid,
    output logic                                  propagated_error_ready,
    output logic [NEURON_NUM*DELTA_WIDTH-1:0]      deltas,
    output logic                                  deltas_valid,
    input  logic                                  deltas_ready
);

    localparam int AW    = ACTIVATION_WIDTH;
    localparam int DW    = DELTA_WIDTH;
    localparam int PW    = DW + AW + 1;
    localparam int CNT_W = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUTPUT} state_t;
    typedef enum logic {MODE_OUT, MODE_HID} mode_t;

    state_t state, next_state;
    mode_t  mode;

    logic             have_act, have_tgt, have_err;
    logic [CNT_W-1:0] idx;
    logic             last_neuron;

    logic [NEURON_NUM*AW-1:0] tgt_q;
    logic [NEURON_NUM*AW-1:0] act_q;
    logic [NEURON_NUM*DW-1:0] err_q;

    logic layer_xfer, layer_ok, act_xfer, tgt_xfer, err_xfer, out_xfer;

    // Datapath signals for the neuron currently selected by idx
    logic        [AW-1:0]   a_i, t_i;
    logic signed [DW-1:0]   err_i;
    logic signed [AW:0]     diff;
    logic        [AW:0]     compl_a;
    logic        [2*AW:0]   dprod;
    logic        [AW-1:0]   deriv;
    logic signed [DW-1:0]   e;
    logic signed [PW-1:0]   prod;
    logic signed [DW:0]     shifted;
    logic        [DW-1:0]   delta_i;

    // Handshake readies decoded purely from state and capture flags
    assign layer_number_ready     = (state == IDLE);
    assign activations_ready      = (state == LOAD) && !have_act;
    assign start_targets_ready    = (state == LOAD) && (mode == MODE_OUT) && !have_tgt;
    assign propagated_error_ready = (state == LOAD) && (mode == MODE_HID) && !have_err;
    assign deltas_valid           = (state == OUTPUT);

    assign layer_xfer = layer_number_valid && layer_number_ready;
    assign act_xfer   = activations_valid && activations_ready;
    assign tgt_xfer   = start_targets_valid && start_targets_ready;
    assign err_xfer   = propagated_error_valid && propagated_error_ready;
    assign out_xfer   = deltas_valid && deltas_ready;

    assign layer_ok    = (layer_number != '0) &&
                         (layer_number <= LAYER_ADDR_WIDTH'(LAYER_MAX));
    assign last_neuron = (idx == CNT_W'(NEURON_NUM - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state decode
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        next_state = state;
        case (state)
            IDLE:    if (layer_xfer && layer_ok) next_state = LOAD;
            LOAD:    if ((have_act || act_xfer) &&
                         ((mode == MODE_OUT) ? (have_tgt || tgt_xfer)
                                             : (have_err || err_xfer)))
                         next_state = COMPUTE;
            COMPUTE: if (last_neuron) next_state = OUTPUT;
            OUTPUT:  if (out_xfer) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Mode, capture flags, neuron counter and result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode     <= MODE_OUT;
            have_act <= 1'b0;
            have_tgt <= 1'b0;
            have_err <= 1'b0;
            idx      <= '0;
            deltas   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            case (state)
                IDLE: begin
                    if (layer_xfer && layer_ok)
                        mode <= (layer_number == LAYER_ADDR_WIDTH'(LAYER_MAX)) ? MODE_OUT : MODE_HID;
                end
                LOAD: begin
                    if (act_xfer) have_act <= 1'b1;
                    if (tgt_xfer) have_tgt <= 1'b1;
                    if (err_xfer) have_err <= 1'b1;
                end
                COMPUTE: begin
                    deltas[idx*DW +: DW] <= delta_i;
                    idx <= last_neuron ? '0 : idx + 1'b1;
                end
                OUTPUT: begin
                    if (out_xfer) begin
                        have_act <= 1'b0;
                        have_tgt <= 1'b0;
                        have_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand holding registers
    // NOTE: pure data registers carry no reset; capture flags gate their use, so stale contents are never consumed.
    always_ff @(posedge clk) begin
        if (act_xfer) act_q <= activations;
        if (tgt_xfer) tgt_q <= start_targets;
        if (err_xfer) err_q <= propagated_error;
    end

    // Per-neuron error, sigmoid derivative, product and saturating rescale
    always_comb begin
        a_i     = act_q[idx*AW +: AW];
        t_i     = tgt_q[idx*AW +: AW];
        err_i   = err_q[idx*DW +: DW];
        diff    = $signed({1'b0, t_i}) - $signed({1'b0, a_i});
        e       = (mode == MODE_OUT) ? DW'(diff) : err_i;
        compl_a = {1'b1, {AW{1'b0}}} - {1'b0, a_i};
        dprod   = (2*AW+1)'(a_i) * (2*AW+1)'(compl_a);
        deriv   = AW'(dprod >> AW);
        prod    = PW'(e) * $signed({{(PW-AW){1'b0}}, deriv});
        shifted = (DW+1)'(prod >>> AW);
        if (shifted[DW] != shifted[DW-1])
            delta_i = shifted[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            delta_i = shifted[DW-1:0];
    end

endmodule

// File: tb/tb_error_controller.sv
// Directed testbench for error_controller with hand-computed delta vectors.
module tb_error_controller;

    localparam int NN  = 5;
    localparam int AW  = 9;
    localparam int DW  = 10;
    localparam int LAW = 2;

    typedef int vec_t[NN];

    logic              clk;
    logic              rst;
    logic [LAW-1:0]    layer_number;
    logic              layer_number_valid;
    logic              layer_number_ready;
    logic [NN*AW-1:0]  start_targets;
    logic              start_targets_valid;
    logic              start_targets_ready;
    logic [NN*AW-1:0]  activations;
    logic              activations_valid;
    logic              activations_ready;
    logic [NN*DW-1:0]  propagated_error;
    logic              propagated_error_valid;
    logic              propagated_error_ready;
    logic [NN*DW-1:0]  deltas;
    logic              deltas_valid;
    logic              deltas_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int watch    = 0;   // 1: HID op, targets unused; 2: OUT op, errors unused
    int unused_hits = 0;

    error_controller dut (
        .clk                    (clk),
        .rst                    (rst),
        .layer_number           (layer_number),
        .layer_number_valid     (layer_number_valid),
        .layer_number_ready     (layer_number_ready),
        .start_targets          (start_targets),
        .start_targets_valid    (start_targets_valid),
        .start_targets_ready    (start_targets_ready),
        .activations            (activations),
        .activations_valid      (activations_valid),
        .activations_ready      (activations_ready),
        .propagated_error       (propagated_error),
        .propagated_error_valid (propagated_error_valid),
        .propagated_error_ready (propagated_error_ready),
        .deltas                 (deltas),
        .deltas_valid           (deltas_valid),
        .deltas_ready           (deltas_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count any ready raised on the stream the current mode does not use
    always @(negedge clk) begin
        if ((watch == 1 && start_targets_ready) || (watch == 2 && propagated_error_ready))
            unused_hits <= unused_hits + 1;
    end

    task automatic check(input string tag, input int got, input int expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NN*AW-1:0] pack_aw(input vec_t v);
        logic [NN*AW-1:0] r;
        r = '0;
        for (int i = 0; i < NN; i++) r[i*AW +: AW] = AW'(v[i]);
        return r;
    endfunction

    function automatic logic [NN*DW-1:0] pack_dw(input vec_t v);
        logic [NN*DW-1:0] r;
        r = '0;
        for (int i = 0; i < NN; i++) r[i*DW +: DW] = DW'(v[i]);
        return r;
    endfunction

    function automatic vec_t splat(input int x);
        vec_t v;
        for (int i = 0; i < NN; i++) v[i] = x;
        return v;
    endfunction

    function automatic int delta_at(input int i);
        return int'($signed(deltas[i*DW +: DW]));
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " deltas_valid"}, int'(deltas_valid), 0);
        check({tag, " layer_rdy"},    int'(layer_number_ready), 1);
        check({tag, " act_rdy"},      int'(activations_ready), 0);
        check({tag, " tgt_rdy"},      int'(start_targets_ready), 0);
        check({tag, " err_rdy"},      int'(propagated_error_ready), 0);
        check({tag, " deltas_zero"},  int'(deltas == '0), 1);
    endtask

    // One full layer operation. A delay of -1 means that stream is never presented.
    // Targets in HID mode stay valid for the whole operation to prove they are ignored.
    task automatic run_layer(input string tag, input int layer, input vec_t tgt, input vec_t act,
                             input vec_t err, input int tgt_dly, input int act_dly,
                             input int err_dly, input int bp, input vec_t expd);
        bit need_tgt, got_a, got_t, got_e, cap_a, cap_t, cap_e;
        int cyc, lat, hits0;
        logic [NN*DW-1:0] snap;
        need_tgt = (layer == 2);
        got_a = 0; got_t = 0; got_e = 0;
        start_targets    = pack_aw(tgt);
        activations      = pack_aw(act);
        propagated_error = pack_dw(err);

        layer_number       = LAW'(layer);
        layer_number_valid = 1'b1;
        check({tag, " layer_rdy_idle"}, int'(layer_number_ready), 1);
        tick;
        layer_number_valid = 1'b0;
        hits0 = unused_hits;
        watch = need_tgt ? 2 : 1;

        cyc = 0;
        while (!(got_a && (need_tgt ? got_t : got_e)) && cyc < 20) begin
            activations_valid      = !got_a && (act_dly >= 0) && (cyc >= act_dly);
            start_targets_valid    = !got_t && (tgt_dly >= 0) && (cyc >= tgt_dly);
            propagated_error_valid = !got_e && (err_dly >= 0) && (cyc >= err_dly);
            cap_a = activations_valid && activations_ready;
            cap_t = start_targets_valid && start_targets_ready;
            cap_e = propagated_error_valid && propagated_error_ready;
            tick;
            cyc++;
            if (cap_a) begin got_a = 1; check({tag, " act_rdy_drop"}, int'(activations_ready), 0); end
            if (cap_t) begin got_t = 1; check({tag, " tgt_rdy_drop"}, int'(start_targets_ready), 0); end
            if (cap_e) begin got_e = 1; check({tag, " err_rdy_drop"}, int'(propagated_error_ready), 0); end
        end
        check({tag, " operands_taken"}, int'(got_a && (need_tgt ? got_t : got_e)), 1);
        activations_valid      = 1'b0;
        propagated_error_valid = 1'b0;
        if (need_tgt) start_targets_valid = 1'b0;

        lat = 0;
        while (!deltas_valid && lat < 20) begin
            tick;
            lat++;
        end
        check({tag, " latency"}, lat, NN);
        for (int i = 0; i < NN; i++)
            check($sformatf("%s delta[%0d]", tag, i), delta_at(i), expd[i]);
        check({tag, " layer_rdy_busy"}, int'(layer_number_ready), 0);

        snap = deltas;
        deltas_ready = 1'b0;
        for (int c = 0; c < bp; c++) begin
            tick;
            check($sformatf("%s bp_valid c%0d", tag, c), int'(deltas_valid), 1);
            check($sformatf("%s bp_stable c%0d", tag, c), int'(deltas == snap), 1);
            check($sformatf("%s bp_layer_rdy c%0d", tag, c), int'(layer_number_ready), 0);
        end
        deltas_ready = 1'b1;
        tick;
        deltas_ready = 1'b0;
        watch = 0;
        start_targets_valid = 1'b0;
        check({tag, " done_valid"},     int'(deltas_valid), 0);
        check({tag, " done_layer_rdy"}, int'(layer_number_ready), 1);
        check({tag, " unused_rdy"},     unused_hits - hits0, 0);
    endtask

    // Out-of-range layer index: consumed in IDLE, nothing else happens
    task automatic drop_layer(input string tag, input int layer);
        int hits;
        hits = 0;
        layer_number       = LAW'(layer);
        layer_number_valid = 1'b1;
        check({tag, " layer_rdy"}, int'(layer_number_ready), 1);
        tick;
        layer_number_valid     = 1'b0;
        activations_valid      = 1'b1;
        start_targets_valid    = 1'b1;
        propagated_error_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (activations_ready || start_targets_ready || propagated_error_ready ||
                deltas_valid || !layer_number_ready)
                hits++;
            tick;
        end
        activations_valid      = 1'b0;
        start_targets_valid    = 1'b0;
        propagated_error_valid = 1'b0;
        check({tag, " no_activity"}, hits, 0);
        check({tag, " still_idle"}, int'(layer_number_ready), 1);
    endtask

    initial begin
        vec_t zero_v, exp_mix, tgt_mix, act_mix, err_mix, exp_hmix;
        zero_v   = splat(0);
        tgt_mix  = '{511, 0, 100, 300, 10};
        act_mix  = '{256, 256, 0, 100, 400};
        exp_mix  = '{63, -64, 0, 31, -67};
        err_mix  = '{-100, 200, 511, -512, 0};
        exp_hmix = '{-19, 37, 95, -96, 0};

        rst = 1'b0;
        layer_number = '0;
        layer_number_valid = 1'b0;
        start_targets = '0;
        start_targets_valid = 1'b0;
        activations = '0;
        activations_valid = 1'b0;
        propagated_error = '0;
        propagated_error_valid = 1'b0;
        deltas_ready = 1'b0;

        tick; tick; tick;
        check_reset_outputs("reset");
        rst = 1'b1;
        tick;
        check_reset_outputs("post_reset");

        // Output layer, uniform vectors
        run_layer("out_63",  2, splat(511), splat(256), zero_v, 0, 0, -1, 0, splat(63));
        run_layer("out_m64", 2, splat(0),   splat(256), zero_v, 0, 0, -1, 0, splat(-64));
        run_layer("out_0",   2, splat(0),   splat(0),   zero_v, 0, 0, -1, 0, splat(0));
        run_layer("out_mix", 2, tgt_mix,    act_mix,    zero_v, 0, 0, -1, 0, exp_mix);

        // Hidden layer, targets held valid throughout
        run_layer("hid_m19", 1, splat(511), splat(128), splat(-100), 0, 0, 0, 0, splat(-19));
        run_layer("hid_mix", 1, splat(77),  splat(128), err_mix,     0, 0, 0, 0, exp_hmix);

        // Operand ordering
        run_layer("ord_tgt_first", 2, splat(511), splat(256), zero_v, 0, 3, -1, 0, splat(63));
        run_layer("ord_act_first", 2, splat(511), splat(256), zero_v, 3, 0, -1, 0, splat(63));
        run_layer("ord_same",      2, splat(511), splat(256), zero_v, 1, 1, -1, 0, splat(63));
        run_layer("ord_hid_late",  1, splat(0),   splat(128), splat(-100), -1, 0, 2, 0, splat(-19));

        // Backpressure on the result
        run_layer("bp", 2, tgt_mix, act_mix, zero_v, 0, 0, -1, 5, exp_mix);

        // Out-of-range layer requests
        drop_layer("layer0", 0);
        drop_layer("layer3", 3);

        // Reset during COMPUTE at neuron 2
        start_targets    = pack_aw(splat(0));
        activations      = pack_aw(splat(256));
        layer_number     = 2'd2;
        layer_number_valid = 1'b1;
        tick;
        layer_number_valid  = 1'b0;
        activations_valid   = 1'b1;
        start_targets_valid = 1'b1;
        tick;
        activations_valid   = 1'b0;
        start_targets_valid = 1'b0;
        tick; tick;
        check("midrst partial_delta0", delta_at(0), -64);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick;
        rst = 1'b1;
        tick;
        run_layer("after_rst", 2, splat(511), splat(256), zero_v, 0, 0, -1, 0, splat(63));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
